// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches over imem req/ack and presents words to the decoder.
// Optional macro HALT_DETECT_EN: a consumed word with opcode 4'hF stops fetching until a branch.
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted
);

    // Handshakes: a memory transfer completes on a cycle with imem_req && imem_ack, and
    // imem_addr holds until then; a decoder transfer completes on instr_valid && instr_ready,
    // with instr/instr_pc/instr_valid stable until then. branch_en overrides both.
`ifdef HALT_DETECT_EN
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              discard;
    logic              halt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            discard     <= 1'b0;
            halt_q      <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                    if (branch_en) begin
                        pc        <= branch_target;
                        imem_addr <= branch_target;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (branch_en)
                        pc <= branch_target;
                    // A redirected request stays on the bus until its ack, then is reissued at the newest pc.
                    if (discard) begin
                        if (imem_ack) begin
                            discard   <= 1'b0;
                            imem_addr <= branch_en ? branch_target : pc;
                        end
                    end else if (branch_en) begin
                        if (imem_ack)
                            imem_addr <= branch_target;
                        else
                            discard <= 1'b1;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        pc          <= pc + 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (branch_en) begin
                        instr_valid <= 1'b0;
                        pc          <= branch_target;
                        imem_addr   <= branch_target;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
`ifdef HALT_DETECT_EN
                        if (instr[DATA_W-1 -: 4] == 4'hF) begin
                            halt_q <= 1'b1;
                            state  <= HALT;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            state     <= FETCH;
                        end
`else
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= FETCH;
`endif
                    end
                end
`ifdef HALT_DETECT_EN
                HALT: begin
                    if (branch_en) begin
                        halt_q    <= 1'b0;
                        pc        <= branch_target;
                        imem_addr <= branch_target;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HALT_DETECT_EN
    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a word-stream model (consecutive addresses from the last redirect).
module tb_instr_fetch;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          branch_en = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          halted;

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_en(branch_en), .branch_target(branch_target), .halted(halted)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // instruction memory model
    logic [DW-1:0] mem [256];
    int            lat = 0;
    bit            lat_rand = 0;
    bit            hold_en = 0;
    logic [AW-1:0] hold_addr = '0;
    bit            spur_en = 0;
    int            cnt = 0;

    always @(posedge clk) begin
        #1;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (!rst_n) begin
            cnt = lat;
        end else if (imem_req) begin
            if (hold_en && imem_addr == hold_addr) begin
                imem_ack = 1'b0;
            end else if (cnt <= 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                cnt        = lat_rand ? int'($urandom_range(0, 4)) : lat;
            end else begin
                cnt--;
            end
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
            imem_ack = 1'b1;
        end
    end

    // scoreboard: logs and the per-cycle stream model
    logic [AW-1:0] req_q[$];
    logic [AW-1:0] got_pc_q[$];
    logic [DW-1:0] got_instr_q[$];
    int            got_cyc_q[$];
    logic [31:0]   exp_q[$];

    logic [AW-1:0] exp_pc;
    bit            p_valid, p_take, p_br, p_req, p_ack;
    logic [DW-1:0] p_instr;
    logic [AW-1:0] p_pc, p_addr;
    bit            chk_halt0 = 1;
    bit            take;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = '0;
            p_valid = 0; p_take = 0; p_br = 0; p_req = 0; p_ack = 0;
        end else begin
            chk("req_valid_excl", {31'b0, imem_req & instr_valid}, 32'd0);
            if (p_req && !p_ack) begin
                chk("req_held", {31'b0, imem_req}, 32'd1);
                chk("addr_held", {24'b0, imem_addr}, {24'b0, p_addr});
            end
            if (p_valid && !p_take && !p_br) begin
                chk("valid_held", {31'b0, instr_valid}, 32'd1);
                chk("instr_held", instr, p_instr);
                chk("pc_held", {24'b0, instr_pc}, {24'b0, p_pc});
            end else if (instr_valid) begin
                chk("word_pc", {24'b0, instr_pc}, {24'b0, exp_pc});
                chk("word_data", instr, mem[instr_pc]);
            end
            if (chk_halt0)
                chk("halted_low", {31'b0, halted}, 32'd0);
            if (imem_req && imem_ack)
                req_q.push_back(imem_addr);
            take = instr_valid && instr_ready && !branch_en;
            if (take) begin
                got_pc_q.push_back(instr_pc);
                got_instr_q.push_back(instr);
                got_cyc_q.push_back(cyc);
            end
            if (branch_en)
                exp_pc = branch_target;
            else if (take)
                exp_pc = exp_pc + 8'd1;
            p_valid = instr_valid; p_take = take; p_br = branch_en;
            p_req = imem_req; p_ack = imem_ack;
            p_instr = instr; p_pc = instr_pc; p_addr = imem_addr;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic restart();
        branch_en = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        req_q.delete(); got_pc_q.delete(); got_instr_q.delete(); got_cyc_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int k = 0;
        while (got_pc_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, {31'b0, got_pc_q.size() >= n}, 32'd1);
    endtask

    task automatic pulse_branch(input logic [AW-1:0] tgt);
        branch_en = 1'b1;
        branch_target = tgt;
        tick();
        branch_en = 1'b0;
    endtask

    int stall, ack_cyc, val_cyc, last_cyc, last_n, k;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", {24'b0, imem_addr}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", {24'b0, instr_pc}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);

        // back-to-back fetch, same-cycle ack, always ready
        lat = 0; instr_ready = 1'b1;
        restart();
        wait_got(3, 40, "t1_timeout");
        exp_q = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
        for (int i = 0; i < 3; i++) begin
            chk("t1_req_addr", {24'b0, req_q[i]}, i);
            chk("t1_instr", got_instr_q[i], exp_q[i]);
            chk("t1_instr_pc", {24'b0, got_pc_q[i]}, i);
        end
        chk("t1_spacing0", got_cyc_q[1] - got_cyc_q[0], 32'd2);
        chk("t1_spacing1", got_cyc_q[2] - got_cyc_q[1], 32'd2);

        // ack delayed by 3 cycles
        lat = 3; instr_ready = 1'b1;
        restart();
        stall = 0; ack_cyc = -1; val_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_cyc < 0 && imem_req && !imem_ack && imem_addr == 8'd0) stall++;
            if (ack_cyc < 0 && imem_req && imem_ack) ack_cyc = cyc;
            if (val_cyc < 0 && instr_valid) val_cyc = cyc;
        end
        chk("t2_stall_cycles", stall, 32'd3);
        chk("t2_valid_after_ack", val_cyc - ack_cyc, 32'd1);

        // decoder stall
        lat = 0; instr_ready = 1'b0; mem[0] = 32'h1234_5678;
        restart();
        k = 0;
        while (!instr_valid && k < 20) begin tick(); k++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_instr", instr, 32'h1234_5678);
            chk("t3_valid", {31'b0, instr_valid}, 32'd1);
            chk("t3_req_low", {31'b0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        k = 0;
        while (req_q.size() < 2 && k < 20) begin tick(); k++; end
        chk("t3_next_addr", {24'b0, req_q[1]}, 32'd1);
        mem[0] = 32'hA000_0000;

        // redirect during a pending fetch of addr 3
        lat = 0; instr_ready = 1'b1; hold_addr = 8'd3; hold_en = 1;
        restart();
        k = 0;
        while (!(imem_req && imem_addr == 8'd3) && k < 30) begin tick(); k++; end
        pulse_branch(8'h40);
        tick();
        hold_en = 0;
        wait_got(4, 40, "t4_timeout");
        chk("t4_pc2", {24'b0, got_pc_q[2]}, 32'd2);
        chk("t4_branch_pc", {24'b0, got_pc_q[3]}, 32'h40);
        chk("t4_branch_instr", got_instr_q[3], 32'hA000_0040);
        chk("t4_req_stale", {24'b0, req_q[3]}, 32'd3);
        chk("t4_req_redirect", {24'b0, req_q[4]}, 32'h40);

        // PC wrap from 0xFF
        lat = 0; instr_ready = 1'b0;
        restart();
        k = 0;
        while (!instr_valid && k < 20) begin tick(); k++; end
        pulse_branch(8'hFF);
        instr_ready = 1'b1;
        wait_got(2, 40, "t5_timeout");
        chk("t5_pc_ff", {24'b0, got_pc_q[0]}, 32'hFF);
        chk("t5_pc_wrap", {24'b0, got_pc_q[1]}, 32'h00);
        chk("t5_instr_wrap", got_instr_q[1], 32'hA000_0000);
        chk("t5_req_ff", {24'b0, req_q[1]}, 32'hFF);
        chk("t5_req_wrap", {24'b0, req_q[2]}, 32'h00);

        // opcode 4'hF word
        lat = 0; instr_ready = 1'b1; mem[1] = 32'hF000_0000; chk_halt0 = 0;
        restart();
`ifdef HALT_DETECT_EN
        wait_got(2, 40, "t6_timeout");
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_halted", {31'b0, halted}, 32'd1);
            chk("t6_no_req", {31'b0, imem_req}, 32'd0);
            chk("t6_no_valid", {31'b0, instr_valid}, 32'd0);
        end
        pulse_branch(8'h10);
        chk("t6_resume_halted", {31'b0, halted}, 32'd0);
        chk("t6_resume_req", {31'b0, imem_req}, 32'd1);
        chk("t6_resume_addr", {24'b0, imem_addr}, 32'h10);
`else
        wait_got(3, 40, "t6_timeout");
        chk("t6_next_pc", {24'b0, got_pc_q[2]}, 32'd2);
        chk("t6_next_req", {24'b0, req_q[2]}, 32'd2);
        chk("t6_halted_low", {31'b0, halted}, 32'd0);
`endif
        mem[1] = 32'hA000_0001; chk_halt0 = 1;

        // randomized traffic against the stream model
        lat = 2; lat_rand = 1; spur_en = 1;
        restart();
        last_cyc = cyc; last_n = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            instr_ready = ($urandom_range(0, 3) != 0);
            branch_en = ($urandom_range(0, 11) == 0);
            branch_target = AW'($urandom);
            if (got_pc_q.size() != last_n) begin
                last_n = got_pc_q.size();
                last_cyc = cyc;
            end
            if (cyc - last_cyc > 300) begin
                chk("rand_liveness", 32'd0, 32'd1);
                break;
            end
        end
        branch_en = 1'b0;
        chk("rand_progress", {31'b0, got_pc_q.size() > 50}, 32'd1);

        // asynchronous reset in mid-operation
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_addr", {24'b0, imem_addr}, 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_pc", {24'b0, instr_pc}, 32'd0);
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_halted", {31'b0, halted}, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
